// File: rtl/uart_pkg.sv
// Shared UART-side definitions: arbiter FSM encoding and byte width.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-set finder: first asserted req starting at ptr, wrapping mod N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    always_comb begin
        int cand;
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        cand   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!any && req[cand]) begin
                any          = 1'b1;
                index        = IDX_W'(cand);
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-locked round-robin arbiter sharing one byte-wide UART shifter among N_REQ sources.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BYTE_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          grant,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic                      abort
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               tx_start_q, tx_start_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic               abort_q, abort_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               last_q, last_d;

    logic [N_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]   pick_index;
    logic               pick_any;
    logic               hs;
    logic [IDX_W-1:0]   next_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .index  (pick_index),
        .any    (pick_any)
    );

    assign req_ready = (state_q == SEND) ? grant_q : '0;
    assign busy      = (state_q != IDLE);
    assign hs        = (state_q == SEND) && req_valid[owner_q];
    assign next_ptr  = IDX_W'((int'(owner_q) + 1) % N_REQ);

    assign grant     = grant_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign abort     = abort_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        abort_d    = 1'b0;
        gap_d      = gap_q;
        last_d     = last_q;

        case (state_q)
            IDLE: begin
                gap_d = '0;
                if (pick_any) begin
                    state_d = SEND;
                    grant_d = pick_onehot;
                    owner_d = pick_index;
                end
            end
            SEND: begin
                if (hs) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = req_data[int'(owner_q)*BYTE_W +: BYTE_W];
                    last_d     = req_last[owner_q];
                    gap_d      = '0;
                    state_d    = WAIT_DONE;
                end else if (GAP_TIMEOUT != 0) begin
                    // Owner stalled mid-frame: give the shifter to someone else.
                    if (int'(gap_q) + 1 >= GAP_TIMEOUT) begin
                        abort_d  = 1'b1;
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        gap_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            abort_q    <= 1'b0;
            gap_q      <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            abort_q    <= abort_d;
            gap_q      <= gap_d;
            last_q     <= last_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: frame-level round-robin reference model plus directed corner cases.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int GT = 16;

    typedef struct packed {
        logic [N-1:0] g;
        logic [7:0]   d;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic           tx_start, tx_done, busy, abort;
    logic [7:0]     tx_data;
    logic           shf_done = 1'b0;
    logic           man_done = 1'b0;
    logic           allow_abort = 1'b0;
    int             shf_cnt = 0;
    int             cyc = 0;
    int             n_cmp = 0;
    int             n_err = 0;
    int             gap_max = 3;
    int             mdl_ptr = 0;

    logic [8:0]     src_q [N][$];
    logic [8:0]     mdl_q [N][$];
    exp_t           exp_q [$];

    assign tx_done = shf_done | man_done;

    uart_tx_arbiter #(.N_REQ(N), .GAP_TIMEOUT(GT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .busy(busy), .abort(abort)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shifter stand-in: done pulse a random number of cycles after each start.
    always @(posedge clk) begin
        shf_done <= 1'b0;
        if (rst) shf_cnt <= 0;
        else if (tx_start) shf_cnt <= int'($urandom_range(1, 6));
        else if (shf_cnt == 1) begin
            shf_done <= 1'b1;
            shf_cnt  <= 0;
        end else if (shf_cnt > 1) shf_cnt <= shf_cnt - 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic add_src(input int i, input logic [7:0] d, input logic last);
        src_q[i].push_back({last, d});
    endtask

    task automatic add_byte(input int i, input logic [7:0] d, input logic last);
        src_q[i].push_back({last, d});
        mdl_q[i].push_back({last, d});
    endtask

    task automatic push_exp(input int i, input logic [7:0] d);
        exp_t e;
        e.g = '0;
        e.g[i] = 1'b1;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Whole frames in round-robin order from the pointer; pointer moves past each finished owner.
    task automatic plan();
        int found;
        logic [8:0] b;
        forever begin
            found = -1;
            for (int k = 0; k < N; k++)
                if (found < 0 && mdl_q[(mdl_ptr + k) % N].size() > 0) found = (mdl_ptr + k) % N;
            if (found < 0) break;
            do begin
                b = mdl_q[found].pop_front();
                push_exp(found, b[7:0]);
            end while (!b[8]);
            mdl_ptr = (found + 1) % N;
        end
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < max_cyc; t++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
                src_q[2].size() == 0 && src_q[3].size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1'b1);
    endtask

    // Requester drivers: present queue head, pop on handshake, optional gap after non-last bytes.
    initial begin
        logic [N-1:0] hs;
        logic [8:0]   b;
        int           gap_left [N];
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) gap_left[i] = 0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && src_q[i].size() > 0) begin
                    b = src_q[i].pop_front();
                    if (!b[8] && gap_max > 0) gap_left[i] = int'($urandom_range(0, gap_max));
                end
                if (gap_left[i] > 0) begin
                    gap_left[i]--;
                    req_valid[i] = 1'b0;
                end else if (src_q[i].size() > 0) begin
                    b = src_q[i][0];
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = b[7:0];
                    req_last[i]         = b[8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Monitor: every start pulse must match the next expected (owner, byte).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_start_unexpected: got data %0h grant %b, wanted no start", tx_data, grant);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", tx_data, e.d);
                    check("tx_grant", grant, e.g);
                end
            end
            if (abort && !allow_abort) check("abort_unexpected", abort, 1'b0);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no end of test, wanted completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok, lock_bad;
        int   d, a, nf, len;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_abort", abort, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        rst = 1'b0;

        // Single frame, arbitration latency
        @(negedge clk);
        add_byte(0, 8'hA5, 1'b1);
        plan();
        @(negedge clk);
        check("sf_grant_before", grant, 0);
        @(negedge clk);
        check("sf_grant", grant, 4'b0001);
        check("sf_ready", req_ready, 4'b0001);
        wait_idle("sf_idle", 200);
        check("sf_grant_released", grant, 0);

        // Pointer is now 1: req1 must beat req0
        add_byte(0, 8'hA6, 1'b1);
        add_byte(1, 8'hB1, 1'b1);
        plan();
        wait_idle("ptr_idle", 300);

        // Round robin from reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_ptr = 0;
        add_byte(0, 8'h11, 1'b0); add_byte(0, 8'h12, 1'b1);
        add_byte(2, 8'h21, 1'b0); add_byte(2, 8'h22, 1'b1);
        add_byte(3, 8'h31, 1'b0); add_byte(3, 8'h32, 1'b1);
        plan();
        wait_idle("rr_idle", 500);

        // Frame lock
        add_byte(1, 8'h41, 1'b0); add_byte(1, 8'h42, 1'b0); add_byte(1, 8'h43, 1'b1);
        plan();
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (grant == 4'b0010) begin ok = 1'b1; break; end
        end
        check("lock_granted", ok, 1'b1);
        add_byte(0, 8'h51, 1'b1);
        plan();
        lock_bad = 1'b0;
        for (int t = 0; t < 500 && grant == 4'b0010; t++) begin
            if (req_ready[0]) lock_bad = 1'b1;
            @(negedge clk);
        end
        check("lock_ready0", lock_bad, 1'b0);
        wait_idle("lock_idle", 300);

        // Reset mid-frame, then search restarts from index 0
        add_src(2, 8'h61, 1'b0);
        add_src(2, 8'h62, 1'b1);
        push_exp(2, 8'h61);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (grant == 4'b0100 && busy && req_ready == 0) begin ok = 1'b1; break; end
        end
        check("mid_wait_done", ok, 1'b1);
        src_q[2].delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_grant", grant, 0);
        check("mid_tx_start", tx_start, 0);
        check("mid_tx_data", tx_data, 0);
        check("mid_abort", abort, 0);
        check("mid_busy", busy, 0);
        check("mid_ready", req_ready, 0);
        check("mid_exp_empty", exp_q.size(), 0);
        mdl_ptr = 0;
        add_byte(0, 8'h71, 1'b1);
        add_byte(1, 8'h81, 1'b1);
        plan();
        wait_idle("mid_idle", 300);

        // Gap timeout: req2 stalls after a non-last byte, req3 waits
        allow_abort = 1'b1;
        add_src(2, 8'h3C, 1'b0);
        add_src(3, 8'h77, 1'b1);
        push_exp(2, 8'h3C);
        push_exp(3, 8'h77);
        d = 0;
        a = 0;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (tx_done) begin ok = 1'b1; d = cyc; break; end
        end
        check("to_done_seen", ok, 1'b1);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (abort) begin ok = 1'b1; a = cyc; break; end
        end
        check("to_abort_seen", ok, 1'b1);
        check("to_latency", a - d, GT + 1);
        check("to_grant", grant, 0);
        @(negedge clk);
        check("to_abort_width", abort, 0);
        allow_abort = 1'b0;
        mdl_ptr = 0;
        wait_idle("to_idle", 200);

        // Spurious done in IDLE and in SEND
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("sp_idle_busy", busy, 0);
        check("sp_idle_grant", grant, 0);
        add_src(1, 8'h44, 1'b0);
        push_exp(1, 8'h44);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (grant == 4'b0010 && req_ready == 4'b0010 && exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        check("sp_send_reached", ok, 1'b1);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("sp_send_busy", busy, 1'b1);
        check("sp_send_ready", req_ready, 4'b0010);
        check("sp_send_start", tx_start, 0);
        add_src(1, 8'h99, 1'b1);
        push_exp(1, 8'h99);
        mdl_ptr = 2;
        wait_idle("sp_idle", 200);

        // Randomized frames from all requesters
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                nf = int'($urandom_range(0, 3));
                for (int f = 0; f < nf; f++) begin
                    len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++) add_byte(i, 8'($urandom), b == len - 1);
                end
            end
            plan();
            wait_idle("rand_idle", 4000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one byte-wide UART transmitter among N_REQ requesters.
- Grants are round-robin, one frame at a time. A frame is a byte sequence ending with a last-flagged byte.
- The owner is locked until its last byte completes, or until a per-frame gap timeout aborts the frame.
- Sits between command/response sources and the uart_tx shifter. Issues one start pulse per byte and waits for the shifter's done pulse.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GAP_TIMEOUT, 1024, max idle cycles allowed mid-frame with owner req_valid low before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  8*N_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  in  N_REQ  byte is last of frame.
- req_ready  out  N_REQ  byte accepted when req_valid[i]&&req_ready[i].
- grant  out  N_REQ  one-hot current owner, 0 when idle.
- tx_start  out  1  one-cycle pulse, start byte on shifter.
- tx_data  out  8  byte for shifter, held stable from tx_start until tx_done.
- tx_done  in  1  one-cycle pulse from shifter, byte (incl. stop bit) finished.
- busy  out  1  high whenever state != IDLE.
- abort  out  1  one-cycle pulse when a frame is aborted by timeout.

Behaviour:
- Reset values: grant=0, tx_start=0, tx_data=8'h00, abort=0, state=IDLE, rr_ptr=0, gap counter=0, last flag=0.
- Reset mid-frame returns to IDLE immediately. Registered outputs (grant, tx_start, tx_data, abort) clear on the next edge; combinational outputs (req_ready, busy) drop as soon as the state is IDLE. The shifter is reset by the same rst.
- States:
  - IDLE, ARB, SEND, WAIT_DONE.
  - ARB is folded into IDLE: the winner is registered on the edge that leaves IDLE.
- IDLE:
  - If any req_valid, pick the first asserted index searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Next cycle: grant=onehot(winner), state=SEND. Arbitration latency is 1 cycle.
  - No requests: stay in IDLE with grant=0.
- SEND:
  - req_ready[owner]=1, combinational from state and grant. All other req_ready are 0.
  - On handshake at cycle T:
    - latch tx_data=req_data[owner] and last flag=req_last[owner];
    - tx_start=1 during T+1 only;
    - state=WAIT_DONE at T+1;
    - gap counter cleared.
  - Without handshake, the gap counter increments. When it reaches GAP_TIMEOUT (nonzero):
    - abort=1 for one cycle;
    - grant=0, state=IDLE;
    - rr_ptr=owner+1 mod N_REQ.
- WAIT_DONE:
  - req_ready=0. tx_done is sampled only in this state; the shifter never asserts tx_done in the cycle of tx_start.
  - On tx_done with last flag=1: state=IDLE, grant=0, rr_ptr=owner+1 mod N_REQ.
  - On tx_done with last flag=0: state=SEND.
  - No timeout applies in this state.
- tx_done outside WAIT_DONE is ignored.
- Simultaneous events: a new requester asserting while a frame is in progress waits. It is considered only in IDLE, after release.
- A single-byte frame (valid and last together) is legal.
- Back-to-back frames from one requester: after release, rr_ptr has moved past it, so other pending requesters win first. It regains grant when it is the only requester.
- Throughput: a byte accepted at T gives tx_start at T+1. After tx_done at D, the next req_ready is at D+1 at the earliest.
- busy = (state != IDLE), combinational.

Decomposition:
- Shared package uart_pkg:
  - state encodings (IDLE=2'd0, SEND=2'd1, WAIT_DONE=2'd2);
  - byte width constant 8.
- Sub-module rr_pick: combinational N_REQ-wide round-robin first-set finder (inputs req, ptr; outputs onehot, index, any). Reusable by future RX-side dispatchers.

Test Plan:
- Single frame: req0 sends 8'hA5 with last → grant=0001 one cycle after valid; tx_start pulse with tx_data=A5; after tx_done, grant=0 and rr_ptr=1.
- Round robin: req0/req2/req3 each with a 2-byte frame pending, all valid from reset release → grant order 0001, 0100, 1000. tx_data sequence is each frame's bytes in order, with no byte interleaving between frames.
- Frame lock: during req1's 3-byte frame, req0 asserts valid → req_ready[0] stays 0 until req1's last tx_done. req0 is granted next.
- Timeout: GAP_TIMEOUT=16; req2 sends a non-last byte, then drops valid → after tx_done plus 16 SEND cycles, abort pulses for 1 cycle, grant=0, and req3 pending is granted next.
- Reset mid-frame: assert rst during WAIT_DONE → all outputs return to reset values. A new req1 frame afterwards is granted with rr_ptr=0 search order.
- Spurious done: tx_done pulsed in IDLE and in SEND → no state change and no tx_start.
